// File: rtl/urem_seq_pkg.sv
// ============================================================================
// Module  : urem_seq_pkg
// Purpose : Shared FSM state type, default width and clog2 helper for the
//           iterative unsigned divide/remainder engine.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package urem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } urem_state_t;

    localparam int W_DEFAULT = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/urem_step.sv
// ============================================================================
// Module  : urem_step
// Purpose : One combinational restoring-division step: shift the next dividend
//           bit into the partial remainder and subtract the divisor if it fits.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module urem_step
    import urem_seq_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W:0]   p_i,
    input  logic         a_msb_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   p_next_o,
    output logic         q_bit_o
);

    logic [W:0] w_shifted;
    logic [W:0] w_diff;
    logic       w_unused_p_msb;

    // The partial remainder stays below the divisor, so its top bit is always
    // clear on entry and drops out of the shift.
    assign w_unused_p_msb = p_i[W];

    always_comb begin
        w_shifted = {p_i[W-1:0], a_msb_i};
        w_diff    = w_shifted - {1'b0, b_i};
        q_bit_o   = (w_shifted >= {1'b0, b_i});
        p_next_o  = q_bit_o ? w_diff : w_shifted;
    end

endmodule

`default_nettype wire

// File: rtl/urem_seq_ctrl.sv
// ============================================================================
// Module  : urem_seq_ctrl
// Purpose : Fixed-latency iterative bvurem/bvudiv engine with valid/ready
//           handshakes. Optional result checker enabled by UREM_SEQ_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module urem_seq_ctrl
    import urem_seq_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int CNT_W = clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
`ifdef UREM_SEQ_CHECK_EN
    input  logic [W-1:0] chk_val,
    output logic         chk_ok,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] rem,
    output logic [W-1:0] quot
);

    urem_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W:0]       p_q;
    logic [W-2:0]     qsr_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     quot_q;
    logic             out_valid_q;

    logic [W:0]       p_d;
    logic             q_bit_d;
    logic [W-1:0]     qsr_d;

    urem_step #(
        .W (W)
    ) u_step (
        .p_i      (p_q),
        .a_msb_i  (a_q[W-1]),
        .b_i      (b_q),
        .p_next_o (p_d),
        .q_bit_o  (q_bit_d)
    );

    // Quotient bits accumulate here; the visible quot only updates on DONE entry.
    assign qsr_d = {qsr_q, q_bit_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            qsr_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= dividend;
                        b_q     <= divisor;
                        p_q     <= '0;
                        qsr_q   <= '0;
                        cnt_q   <= CNT_W'(W);
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    a_q   <= a_q << 1;
                    p_q   <= p_d;
                    qsr_q <= qsr_d[W-2:0];
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        rem_q       <= p_d[W-1:0];
                        quot_q      <= qsr_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UREM_SEQ_CHECK_EN
    logic [W-1:0] chk_q;
    logic         chk_ok_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q    <= '0;
            chk_ok_q <= 1'b0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                chk_q <= chk_val;
            end
            if (state_q == ITER && cnt_q == CNT_W'(1)) begin
                chk_ok_q <= (p_d[W-1:0] == chk_q);
            end else if (state_q == DONE && out_ready) begin
                chk_ok_q <= 1'b0;
            end
        end
    end

    assign chk_ok = chk_ok_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign rem       = rem_q;
    assign quot      = quot_q;

endmodule

`default_nettype wire

// File: tb/tb_urem_seq_ctrl.sv
// ============================================================================
// Module  : tb_urem_seq_ctrl
// Purpose : Scoreboard bench for urem_seq_ctrl (W=4); honours UREM_SEQ_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_urem_seq_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] rem;
        logic [W-1:0] quot;
        logic         chk;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] rem;
    logic [W-1:0] quot;
`ifdef UREM_SEQ_CHECK_EN
    logic [W-1:0] chk_val;
    logic         chk_ok;
`endif

    exp_t sb[$];
    int   total;
    int   bad;

    urem_seq_ctrl #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef UREM_SEQ_CHECK_EN
        .chk_val   (chk_val),
        .chk_ok    (chk_ok),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rem       (rem),
        .quot      (quot)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_rem(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic logic [W-1:0] ref_quot(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : a / b;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic set_chk(input logic [W-1:0] cv);
`ifdef UREM_SEQ_CHECK_EN
        chk_val = cv;
`else
        if (cv === 'x) $display("note: chk_val unused");
`endif
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] cv, input int stall);
        int   n;
        logic saw_ready;
        exp_t e;
        wait_idle();
        if (!in_ready) return;
        out_ready = (stall == 0);
        dividend  = a;
        divisor   = b;
        set_chk(cv);
        in_valid  = 1'b1;
        e.rem  = ref_rem(a, b);
        e.quot = ref_quot(a, b);
        e.chk  = (cv == e.rem);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        set_chk(W'($urandom));
        n = 0;
        saw_ready = 1'b0;
        while (!out_valid && n < 3 * W) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(W));
        check("busy_in_ready", 32'(saw_ready), 32'd0);
        if (stall > 0) begin
            repeat (stall) begin
                in_valid = 1'($urandom_range(0, 1));
                dividend = W'($urandom);
                divisor  = W'($urandom);
                @(posedge clk); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            check("back_to_idle", 32'({in_ready, out_valid}), 32'd2);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t         e;
        logic         pv;
        logic         phs;
        logic [W-1:0] pr;
        logic [W-1:0] pq;
        pv = 1'b0; phs = 1'b0; pr = '0; pq = '0;
        forever begin
            @(negedge clk);
            if (out_valid && pv && !phs) begin
                check("hold_rem", 32'(rem), 32'(pr));
                check("hold_quot", 32'(quot), 32'(pq));
            end
`ifdef UREM_SEQ_CHECK_EN
            if (!out_valid) check("chk_ok_idle", 32'(chk_ok), 32'd0);
`endif
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got rem=%0d quot=%0d with empty scoreboard", rem, quot);
                end else begin
                    e = sb.pop_front();
                    check("rem", 32'(rem), 32'(e.rem));
                    check("quot", 32'(quot), 32'(e.quot));
`ifdef UREM_SEQ_CHECK_EN
                    check("chk_ok", 32'(chk_ok), 32'(e.chk));
`endif
                end
            end
            pv  = out_valid;
            phs = out_valid && out_ready;
            pr  = rem;
            pq  = quot;
        end
    end

    initial begin
        int         n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        total = 0; bad = 0;
        clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        dividend = '0; divisor = '0;
        set_chk('0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_quot", 32'(quot), 32'd0);
        rst = 1'b0;

        do_op(4'd13, 4'd4, 4'd1, 0);
        do_op(4'd13, 4'd4, 4'd2, 0);
        do_op(4'd7,  4'd0, 4'd7, 0);
        do_op(4'd0,  4'd0, 4'd0, 0);
        do_op(4'd3,  4'd9, 4'd3, 0);
        do_op(4'd15, 4'd1, 4'd0, 0);
        do_op(4'd14, 4'd5, 4'd4, 6);

        // Abort two edges into ITER: outputs clear at once, no result emerges.
        wait_idle();
        out_ready = 1'b1; dividend = 4'd11; divisor = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_iter_valid", 32'(out_valid), 32'd0);
        check("abort_iter_rem", 32'(rem), 32'd0);
        check("abort_iter_quot", 32'(quot), 32'd0);
        check("abort_iter_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        do_op(4'd9, 4'd2, 4'd1, 0);

        // Abort while holding a result in DONE.
        wait_idle();
        out_ready = 1'b0; dividend = 4'd14; divisor = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 3 * W) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_done_reached", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_done_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ra = W'(a);
                rb = W'(b);
                do_op(ra, rb, ($urandom_range(0, 1) == 1) ? ref_rem(ra, rb) : W'($urandom), 0);
            end
        end

        repeat (120) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, ($urandom_range(0, 1) == 1) ? ref_rem(ra, rb) : W'($urandom),
                  int'($urandom_range(0, 3)));
        end

        repeat (W + 4) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
